// File: rtl/alu_op_sequencer.sv
// Request queue and issue sequencer for an 8-bit combinational ALU, plus its generic FIFO.
// Latency: request accepted at edge N into an idle block -> rsp_valid high after edge N+2.
// Backpressure: req_ready drops when the queue is full; the response and ALU lines hold until rsp_ready.

// Generic synchronous FIFO, no bypass: an entry pushed at edge N is visible at out_dat after N.
// Latency: one edge from push to out_vld.
// Backpressure: in_rdy low when full (no pass-through on a same-cycle pop); out_vld low when empty.
module fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [W-1:0]             in_dat,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [W-1:0]             out_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign in_rdy  = (count != FULL_CNT);
  assign out_vld = (count != '0);
  assign push    = in_vld && in_rdy;
  assign pop     = out_vld && out_rdy;
  assign out_dat = mem[rd_ptr];

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_dat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

module alu_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [7:0]               req_a,
  input  logic [7:0]               req_b,
  input  logic [3:0]               req_sel,
  input  logic [TAG_W-1:0]         req_tag,
  output logic [7:0]               alu_a,
  output logic [7:0]               alu_b,
  output logic [3:0]               alu_sel,
  input  logic [7:0]               alu_out,
  input  logic                     alu_carry,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [7:0]               rsp_result,
  output logic                     rsp_carry,
  output logic                     rsp_zero,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);

  typedef struct packed {
    logic [7:0]       a;
    logic [7:0]       b;
    logic [3:0]       sel;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  state_t           state;
  state_t           state_n;
  req_t             req_dat;
  req_t             head_dat;
  logic             fifo_rdy;
  logic             head_vld;
  logic             pop;
  logic [TAG_W-1:0] tag_q;

  assign req_dat   = '{a: req_a, b: req_b, sel: req_sel, tag: req_tag};
  assign req_ready = rst_n && fifo_rdy;

  fifo #(.DEPTH(DEPTH), .W($bits(req_t))) u_req_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (req_valid),
    .in_rdy  (fifo_rdy),
    .in_dat  (req_dat),
    .out_vld (head_vld),
    .out_rdy (pop),
    .out_dat (head_dat),
    .count   (count)
  );

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (head_vld) begin
          pop     = 1'b1;
          state_n = DRIVE;
        end
      end
      DRIVE: state_n = RESP;
      RESP: begin
        // Chain straight into the next operation on the handshake edge to sustain 1 per 2 cycles.
        if (rsp_ready) begin
          if (head_vld) begin
            pop     = 1'b1;
            state_n = DRIVE;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      tag_q      <= '0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_tag    <= '0;
    end else begin
      state <= state_n;
      if (pop) begin
        alu_a   <= head_dat.a;
        alu_b   <= head_dat.b;
        alu_sel <= head_dat.sel;
        tag_q   <= head_dat.tag;
      end
      // The ALU has had the whole DRIVE cycle to settle on the registered operands.
      if (state == DRIVE) begin
        rsp_result <= alu_out;
        rsp_carry  <= alu_carry;
        rsp_zero   <= (alu_out == 8'h00);
        rsp_tag    <= tag_q;
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE) || (count != '0);

endmodule
